// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bundle: decode fields, pipeline control, forwarding sources and EX-side results.
interface id_ex_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1_addr;
  logic [RA_W-1:0] id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic [3:0]      id_alu_ctrl;
  logic [RA_W-1:0] id_rd_addr;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            ex_hold;
  logic            flush;
  logic [RA_W-1:0] mem_rd_addr;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [RA_W-1:0] wb_rd_addr;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;
  logic            load_use_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_op_a;
  logic [XLEN-1:0] ex_op_b;
  logic [XLEN-1:0] ex_store_data;
  logic [3:0]      ex_alu_ctrl;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_rd_addr, id_reg_write, id_mem_read,
           ex_hold, flush, mem_rd_addr, mem_reg_write, mem_result,
           wb_rd_addr, wb_reg_write, wb_result,
    input  load_use_stall, ex_valid, ex_op_a, ex_op_b, ex_store_data,
           ex_alu_ctrl, ex_rd_addr, ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_rd_addr, id_reg_write, id_mem_read,
           ex_hold, flush, mem_rd_addr, mem_reg_write, mem_result,
           wb_rd_addr, wb_reg_write, wb_result,
    output load_use_stall, ex_valid, ex_op_a, ex_op_b, ex_store_data,
           ex_alu_ctrl, ex_rd_addr, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding (EX/MEM, MEM/WB) and load-use hazard detection.
module id_ex_operand_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RA_W      = 5,
  parameter bit          FWD_WB_EN = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  id_ex_operand_stage_if.slave  bus
);

  logic            valid_q;
  logic [RA_W-1:0] rs1_addr_q;
  logic [RA_W-1:0] rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;
  logic [3:0]      alu_ctrl_q;
  logic [RA_W-1:0] rd_addr_q;
  logic            reg_write_q;
  logic            mem_read_q;

  logic            stall_c;
  logic            capture_c;
  logic            bubble_c;
  logic [XLEN-1:0] fwd_rs1_c;
  logic [XLEN-1:0] fwd_rs2_c;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic [XLEN-1:0] rf_data,
    input logic [RA_W-1:0] m_rd,
    input logic            m_we,
    input logic [XLEN-1:0] m_res,
    input logic [RA_W-1:0] w_rd,
    input logic            w_we,
    input logic [XLEN-1:0] w_res
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      r = m_res;
    end else if (FWD_WB_EN && w_we && (w_rd != '0) && (w_rd == src)) begin
      r = w_res;
    end
    return r;
  endfunction

  // Load in EX feeding a source the ID instruction actually reads.
  always_comb begin
    stall_c = 1'b0;
    if (valid_q && mem_read_q && (rd_addr_q != '0) && bus.id_valid) begin
      stall_c = (bus.id_rs1_addr == rd_addr_q) ||
                ((bus.id_rs2_addr == rd_addr_q) && !bus.id_use_imm);
    end
  end

  // Update priority: flush, hold, load-use bubble, capture, idle bubble.
  always_comb begin
    capture_c = 1'b0;
    bubble_c  = 1'b0;
    if (bus.flush) begin
      bubble_c = 1'b1;
    end else if (bus.ex_hold) begin
      bubble_c = 1'b0;
    end else if (stall_c) begin
      bubble_c = 1'b1;
    end else if (bus.id_valid) begin
      capture_c = 1'b1;
    end else begin
      bubble_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_ctrl_q  <= 4'b0000;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (capture_c) begin
      valid_q     <= 1'b1;
      rs1_addr_q  <= bus.id_rs1_addr;
      rs2_addr_q  <= bus.id_rs2_addr;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      use_imm_q   <= bus.id_use_imm;
      alu_ctrl_q  <= bus.id_alu_ctrl;
      rd_addr_q   <= bus.id_rd_addr;
      reg_write_q <= bus.id_reg_write;
      mem_read_q  <= bus.id_mem_read;
    end else if (bubble_c) begin
      valid_q     <= 1'b0;
      alu_ctrl_q  <= 4'b0000;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end
  end

  // Operands re-evaluate every cycle so a held instruction sees current MEM/WB values.
  always_comb begin
    fwd_rs1_c = fwd_sel(rs1_addr_q, rs1_data_q, bus.mem_rd_addr, bus.mem_reg_write,
                        bus.mem_result, bus.wb_rd_addr, bus.wb_reg_write, bus.wb_result);
    fwd_rs2_c = fwd_sel(rs2_addr_q, rs2_data_q, bus.mem_rd_addr, bus.mem_reg_write,
                        bus.mem_result, bus.wb_rd_addr, bus.wb_reg_write, bus.wb_result);
  end

  assign bus.load_use_stall = stall_c;
  assign bus.ex_valid       = valid_q;
  assign bus.ex_op_a        = fwd_rs1_c;
  assign bus.ex_op_b        = use_imm_q ? imm_q : fwd_rs2_c;
  assign bus.ex_store_data  = fwd_rs2_c;
  assign bus.ex_alu_ctrl    = alu_ctrl_q;
  assign bus.ex_rd_addr     = rd_addr_q;
  assign bus.ex_reg_write   = reg_write_q & valid_q;
  assign bus.ex_mem_read    = mem_read_q & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, randomized run against a slot model, async reset.
module tb_id_ex_operand_stage;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, AND_ = 4'b0111, OR_ = 4'b0110, SLT = 4'b0010;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  id_ex_operand_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .RA_W(5), .FWD_WB_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        idv;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        ui;
    logic [3:0]  ctrl;
    logic        rw, mr, hold, flush;
    logic [4:0]  mrd, wrd;
    logic        mrw, wrw;
    logic [31:0] mres, wres;
    logic        e_stall, e_valid, e_mr;
    logic [31:0] e_a, e_b, e_st;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
  } vec_t;

  // Instruction occupying the EX slot, as the model sees it.
  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        ui;
    logic [3:0]  ctrl;
    logic        rw, mr;
  } slot_t;

  vec_t  tbl[$];
  slot_t m;

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t idv(input vec_t vi, input logic [4:0] rs1, rs2, input logic [31:0] d1, d2, imm,
                               input logic ui, input logic [3:0] ctrl, input logic [4:0] rd, input logic rw, mr);
    vec_t v;
    v = vi;
    v.idv = 1'b1; v.rs1 = rs1; v.rs2 = rs2; v.d1 = d1; v.d2 = d2; v.imm = imm;
    v.ui = ui; v.ctrl = ctrl; v.rd = rd; v.rw = rw; v.mr = mr;
    return v;
  endfunction

  function automatic vec_t fm(input vec_t vi, input logic [4:0] rd, input logic [31:0] res);
    vec_t v;
    v = vi; v.mrw = 1'b1; v.mrd = rd; v.mres = res;
    return v;
  endfunction

  function automatic vec_t fw(input vec_t vi, input logic [4:0] rd, input logic [31:0] res);
    vec_t v;
    v = vi; v.wrw = 1'b1; v.wrd = rd; v.wres = res;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic stall, valid, input logic [31:0] a, b, st,
                              input logic [3:0] ctrl, input logic [4:0] rd, input logic mr);
    vec_t v;
    v = vi; v.e_stall = stall; v.e_valid = valid; v.e_a = a; v.e_b = b; v.e_st = st;
    v.e_ctrl = ctrl; v.e_rd = rd; v.e_mr = mr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid = v.idv;       bus.id_rs1_addr = v.rs1;   bus.id_rs2_addr = v.rs2;
    bus.id_rs1_data = v.d1;     bus.id_rs2_data = v.d2;    bus.id_imm = v.imm;
    bus.id_use_imm = v.ui;      bus.id_alu_ctrl = v.ctrl;  bus.id_rd_addr = v.rd;
    bus.id_reg_write = v.rw;    bus.id_mem_read = v.mr;    bus.ex_hold = v.hold;
    bus.flush = v.flush;        bus.mem_rd_addr = v.mrd;   bus.mem_reg_write = v.mrw;
    bus.mem_result = v.mres;    bus.wb_rd_addr = v.wrd;    bus.wb_reg_write = v.wrw;
    bus.wb_result = v.wres;
  endtask

  // Model: most recent writer wins (MEM newer than WB); x0 is hardwired.
  function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return rf;
    if (bus.mem_reg_write && bus.mem_rd_addr == src) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd_addr == src) return bus.wb_result;
    return rf;
  endfunction

  function automatic logic model_stall();
    logic reads_rd;
    if (!(m.v && m.mr) || m.rd == 5'd0 || !bus.id_valid) return 1'b0;
    reads_rd = (bus.id_rs1_addr == m.rd) || (!bus.id_use_imm && bus.id_rs2_addr == m.rd);
    return reads_rd;
  endfunction

  task automatic model_check(input int cyc);
    string s;
    s = $sformatf("rnd%0d", cyc);
    chk({s, ".stall"}, 32'(bus.load_use_stall), 32'(model_stall()));
    chk({s, ".valid"}, 32'(bus.ex_valid), 32'(m.v));
    chk({s, ".ctrl"},  32'(bus.ex_alu_ctrl), m.v ? 32'(m.ctrl) : 32'd0);
    chk({s, ".rd"},    32'(bus.ex_rd_addr), m.v ? 32'(m.rd) : 32'd0);
    chk({s, ".rw"},    32'(bus.ex_reg_write), 32'(m.v && m.rw));
    chk({s, ".mr"},    32'(bus.ex_mem_read), 32'(m.v && m.mr));
    if (m.v) begin
      chk({s, ".op_a"},  bus.ex_op_a, model_fwd(m.rs1, m.d1));
      chk({s, ".op_b"},  bus.ex_op_b, m.ui ? m.imm : model_fwd(m.rs2, m.d2));
      chk({s, ".store"}, bus.ex_store_data, model_fwd(m.rs2, m.d2));
    end
  endtask

  task automatic model_step();
    slot_t nxt;
    nxt = '{default: '0};
    if (bus.flush) m = nxt;
    else if (bus.ex_hold) m = m;
    else if (model_stall()) m = nxt;
    else if (bus.id_valid) begin
      nxt.v = 1'b1; nxt.rs1 = bus.id_rs1_addr; nxt.rs2 = bus.id_rs2_addr; nxt.rd = bus.id_rd_addr;
      nxt.d1 = bus.id_rs1_data; nxt.d2 = bus.id_rs2_data; nxt.imm = bus.id_imm;
      nxt.ui = bus.id_use_imm; nxt.ctrl = bus.id_alu_ctrl; nxt.rw = bus.id_reg_write;
      nxt.mr = bus.id_mem_read;
      m = nxt;
    end else m = nxt;
  endtask

  initial begin
    vec_t        v;
    logic [3:0]  ops [5];
    string       s;
    n_vec = 0;
    n_err = 0;
    ops[0] = ADD; ops[1] = SUB; ops[2] = AND_; ops[3] = OR_; ops[4] = SLT;

    // Directed table: expectations are what EX shows during that row, before its clock edge.
    tbl.push_back(ex(idv(idle(), 5, 6, 32'h99, 32'h66, 0, 0, ADD, 8, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(fm(idle(), 5, 32'h10), 0, 1, 32'h10, 32'h66, 32'h66, ADD, 8, 0));
    tbl.push_back(ex(idv(idle(), 7, 7, 32'h77, 32'h77, 0, 0, SUB, 9, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    v = fw(fm(idle(), 7, 32'hA), 7, 32'hB); v.hold = 1'b1;
    tbl.push_back(ex(v, 0, 1, 32'hA, 32'hA, 32'hA, SUB, 9, 0));
    v = fw(fm(idle(), 0, 32'h55), 0, 32'h55); v.hold = 1'b1;
    tbl.push_back(ex(v, 0, 1, 32'h77, 32'h77, 32'h77, SUB, 9, 0));
    tbl.push_back(ex(fw(idle(), 7, 32'hB), 0, 1, 32'hB, 32'hB, 32'hB, SUB, 9, 0));
    tbl.push_back(ex(idv(idle(), 1, 0, 32'h100, 0, 4, 1, ADD, 3, 1, 1), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idv(idle(), 3, 1, 32'h33, 32'h11, 0, 0, ADD, 4, 1, 0), 1, 1, 32'h100, 4, 0, ADD, 3, 1));
    tbl.push_back(ex(idv(idle(), 3, 1, 32'h33, 32'h11, 0, 0, ADD, 4, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(fm(idle(), 3, 32'hDEAD), 0, 1, 32'hDEAD, 32'h11, 32'h11, ADD, 4, 0));
    tbl.push_back(ex(idv(idle(), 2, 6, 32'h20, 32'h1, 32'hFFFF_FFFC, 1, ADD, 5, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(fm(idle(), 6, 32'h7), 0, 1, 32'h20, 32'hFFFF_FFFC, 32'h7, ADD, 5, 0));
    tbl.push_back(ex(idv(idle(), 1, 2, 32'h5, 32'h6, 0, 0, OR_, 10, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    v = idle(); v.hold = 1'b1; v.flush = 1'b1;
    tbl.push_back(ex(v, 0, 1, 32'h5, 32'h6, 32'h6, OR_, 10, 0));
    tbl.push_back(ex(idle(), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idv(idle(), 1, 2, 32'h5, 32'h6, 0, 0, AND_, 11, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    v = idv(idle(), 9, 9, 32'hAA, 32'hBB, 0, 0, SUB, 12, 1, 0); v.hold = 1'b1;
    for (int k = 0; k < 3; k++) tbl.push_back(ex(v, 0, 1, 32'h5, 32'h6, 32'h6, AND_, 11, 0));
    tbl.push_back(ex(idle(), 0, 1, 32'h5, 32'h6, 32'h6, AND_, 11, 0));
    tbl.push_back(ex(idle(), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idv(idle(), 1, 0, 32'h40, 0, 8, 1, ADD, 3, 1, 1), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idv(idle(), 4, 3, 32'h1, 32'h2, 32'h10, 1, ADD, 6, 1, 0), 0, 1, 32'h40, 8, 0, ADD, 3, 1));
    tbl.push_back(ex(idle(), 0, 1, 32'h1, 32'h10, 32'h2, ADD, 6, 0));

    rst_n = 1'b0;
    drive(idle());
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(bus.ex_valid), 0);
    chk("reset.ctrl",  32'(bus.ex_alu_ctrl), 0);
    chk("reset.rd",    32'(bus.ex_rd_addr), 0);
    chk("reset.rw",    32'(bus.ex_reg_write), 0);
    chk("reset.mr",    32'(bus.ex_mem_read), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      s = $sformatf("row%0d", i);
      chk({s, ".stall"}, 32'(bus.load_use_stall), 32'(tbl[i].e_stall));
      chk({s, ".valid"}, 32'(bus.ex_valid), 32'(tbl[i].e_valid));
      chk({s, ".ctrl"},  32'(bus.ex_alu_ctrl), 32'(tbl[i].e_ctrl));
      chk({s, ".rd"},    32'(bus.ex_rd_addr), 32'(tbl[i].e_rd));
      chk({s, ".rw"},    32'(bus.ex_reg_write), 32'(tbl[i].e_valid));
      chk({s, ".mr"},    32'(bus.ex_mem_read), 32'(tbl[i].e_mr));
      if (tbl[i].e_valid) begin
        chk({s, ".op_a"},  bus.ex_op_a, tbl[i].e_a);
        chk({s, ".op_b"},  bus.ex_op_b, tbl[i].e_b);
        chk({s, ".store"}, bus.ex_store_data, tbl[i].e_st);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Re-synchronise the model from a fresh reset before the random run.
    rst_n = 1'b0;
    drive(idle());
    #2;
    rst_n = 1'b1;
    m = '{default: '0};
    @(negedge clk);

    for (int c = 0; c < 800; c++) begin
      v = idle();
      v.idv  = ($urandom_range(0, 3) != 0);
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.rd   = 5'($urandom_range(0, 3));
      v.d1   = $urandom; v.d2 = $urandom; v.imm = $urandom;
      v.ui   = 1'($urandom_range(0, 1));
      v.ctrl = ops[$urandom_range(0, 4)];
      v.rw   = 1'($urandom_range(0, 1));
      v.mr   = ($urandom_range(0, 2) == 0);
      v.hold = ($urandom_range(0, 7) == 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.mrw  = 1'($urandom_range(0, 1)); v.mrd = 5'($urandom_range(0, 3)); v.mres = $urandom;
      v.wrw  = 1'($urandom_range(0, 1)); v.wrd = 5'($urandom_range(0, 3)); v.wres = $urandom;
      drive(v);
      #1;
      model_check(c);
      model_step();
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted between clock edges must clear EX immediately.
    drive(idv(idle(), 1, 2, 32'h1, 32'h2, 0, 0, SUB, 7, 1, 1));
    @(posedge clk);
    #2;
    chk("midrst.pre_valid", 32'(bus.ex_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.ex_valid), 0);
    chk("midrst.ctrl",  32'(bus.ex_alu_ctrl), 0);
    chk("midrst.rw",    32'(bus.ex_reg_write), 0);
    chk("midrst.mr",    32'(bus.ex_mem_read), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
